// File: rtl/proc_test_sequencer.sv
// rtl/proc_test_sequencer.sv - self-test sequencer running a program table on the single-cycle processor
//
// Purpose: for each table entry, holds the processor in reset with the
// entry's start PC, releases it, waits for currentpc to reach the entry's
// end PC (bounded by a watchdog) and compares MemtoRegOut with the expected
// value. Results are gathered into a pass count and pass/timeout masks.
//
// Optional build macro: STOP_ON_FAIL_EN - when defined, the first failing
// program (mismatch or timeout) ends the sequence; cur_prog keeps its index.
//
// Ports:
//   CLK           clock, rising edge
//   resetl        synchronous active-low reset
//   start         one-cycle pulse, begins a sequence when idle/done
//   prog_start    packed start PCs, program i at [i*PC_W +: PC_W]
//   prog_end      packed end PCs, same packing
//   prog_expect   packed expected results, program i at [i*DATA_W +: DATA_W]
//   currentpc     processor PC
//   MemtoRegOut   processor result
//   dut_resetl    registered active-low reset to the processor
//   dut_startpc   registered start PC to the processor
//   busy          sequence in progress
//   done          sequence complete, held until next start
//   all_pass      valid with done: every program passed
//   pass_count    number of programs passed
//   pass_mask     bit i set when program i passed
//   timeout_mask  bit i set when program i hit the watchdog
//   cur_prog      index of the current program

module proc_test_sequencer #(
  parameter int NUM_PROGS  = 2,
  parameter int PC_W       = 64,
  parameter int DATA_W     = 64,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 255,
  parameter int RST_CYCLES = 2
) (
  input  logic                                              CLK,
  input  logic                                              resetl,
  input  logic                                              start,
  input  logic [NUM_PROGS*PC_W-1:0]                         prog_start,
  input  logic [NUM_PROGS*PC_W-1:0]                         prog_end,
  input  logic [NUM_PROGS*DATA_W-1:0]                       prog_expect,
  input  logic [PC_W-1:0]                                   currentpc,
  input  logic [DATA_W-1:0]                                 MemtoRegOut,
  output logic                                              dut_resetl,
  output logic [PC_W-1:0]                                   dut_startpc,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              all_pass,
  output logic [$clog2(NUM_PROGS+1)-1:0]                    pass_count,
  output logic [NUM_PROGS-1:0]                              pass_mask,
  output logic [NUM_PROGS-1:0]                              timeout_mask,
  output logic [((NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1)-1:0] cur_prog
);

  localparam int CNT_W = $clog2(NUM_PROGS + 1);
  localparam int CP_W  = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CP_W-1:0]   LAST_PROG = CP_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]  ALL_CNT   = CNT_W'(NUM_PROGS);
  localparam logic [RC_W-1:0]   RST_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_LIMIT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    RUN  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Unpacked views of the packed program table
  logic [PC_W-1:0]   start_a  [NUM_PROGS];
  logic [PC_W-1:0]   end_a    [NUM_PROGS];
  logic [DATA_W-1:0] expect_a [NUM_PROGS];

  for (genvar g = 0; g < NUM_PROGS; g++) begin : g_unpack
    assign start_a[g]  = prog_start[g*PC_W +: PC_W];
    assign end_a[g]    = prog_end[g*PC_W +: PC_W];
    assign expect_a[g] = prog_expect[g*DATA_W +: DATA_W];
  end

  logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic [WDOG_W-1:0] wdog, wdog_nxt;
  logic [CP_W-1:0]   cur_prog_nxt;
  logic [CNT_W-1:0]  pass_count_nxt;
  logic [NUM_PROGS-1:0] pass_mask_nxt, timeout_mask_nxt;
  logic [PC_W-1:0]   startpc_nxt;
  logic              all_pass_nxt;
  logic              stop_seq;

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    rst_cnt_nxt      = rst_cnt;
    wdog_nxt         = wdog;
    cur_prog_nxt     = cur_prog;
    pass_count_nxt   = pass_count;
    pass_mask_nxt    = pass_mask;
    timeout_mask_nxt = timeout_mask;
    startpc_nxt      = dut_startpc;
    all_pass_nxt     = all_pass;
    stop_seq         = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt        = RST;
          rst_cnt_nxt      = '0;
          cur_prog_nxt     = '0;
          pass_count_nxt   = '0;
          pass_mask_nxt    = '0;
          timeout_mask_nxt = '0;
          all_pass_nxt     = 1'b0;
          startpc_nxt      = start_a[0];
        end
      end

      RST: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt = RUN;
          wdog_nxt  = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + RC_W'(1);
        end
      end

      RUN: begin
        // End-of-program detection outranks the watchdog in the same cycle
        if (currentpc >= end_a[cur_prog]) begin
          if (MemtoRegOut == expect_a[cur_prog]) begin
            pass_mask_nxt[cur_prog] = 1'b1;
            pass_count_nxt          = pass_count + CNT_W'(1);
          end
          state_nxt = NEXT;
        end else if (wdog == WDOG_MAX) begin
          timeout_mask_nxt[cur_prog] = 1'b1;
          state_nxt                  = NEXT;
        end else begin
          wdog_nxt = wdog + WDOG_W'(1);
        end
      end

      NEXT: begin
`ifdef STOP_ON_FAIL_EN
        // pass_mask was updated on RUN exit, so a clear bit means this program failed
        stop_seq = (cur_prog == LAST_PROG) || !pass_mask[cur_prog];
`else
        stop_seq = (cur_prog == LAST_PROG);
`endif
        if (stop_seq) begin
          state_nxt    = DONE;
          all_pass_nxt = (pass_count == ALL_CNT);
        end else begin
          cur_prog_nxt = cur_prog + CP_W'(1);
          rst_cnt_nxt  = '0;
          startpc_nxt  = start_a[cur_prog_nxt];
          state_nxt    = RST;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      rst_cnt      <= '0;
      wdog         <= '0;
      cur_prog     <= '0;
      pass_count   <= '0;
      pass_mask    <= '0;
      timeout_mask <= '0;
      all_pass     <= 1'b0;
      dut_startpc  <= '0;
      dut_resetl   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rst_cnt      <= rst_cnt_nxt;
      wdog         <= wdog_nxt;
      cur_prog     <= cur_prog_nxt;
      pass_count   <= pass_count_nxt;
      pass_mask    <= pass_mask_nxt;
      timeout_mask <= timeout_mask_nxt;
      all_pass     <= all_pass_nxt;
      dut_startpc  <= startpc_nxt;
      dut_resetl   <= (state_nxt == RUN);
      busy         <= (state_nxt == RST) || (state_nxt == RUN) || (state_nxt == NEXT);
      done         <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// tb/tb_proc_test_sequencer.sv - self-checking bench for proc_test_sequencer

module tb_proc_test_sequencer;

  localparam int NP         = 2;
  localparam int PC_W       = 64;
  localparam int DATA_W     = 64;
  localparam int WDOG_W     = 16;
  localparam int WDOG_LIMIT = 255;
  localparam int RST_CYCLES = 2;

  logic                   CLK = 1'b0;
  logic                   resetl;
  logic                   start;
  logic [NP*PC_W-1:0]     prog_start;
  logic [NP*PC_W-1:0]     prog_end;
  logic [NP*DATA_W-1:0]   prog_expect;
  logic [PC_W-1:0]        currentpc;
  logic [DATA_W-1:0]      MemtoRegOut;
  logic                   dut_resetl;
  logic [PC_W-1:0]        dut_startpc;
  logic                   busy, done, all_pass;
  logic [1:0]             pass_count;
  logic [NP-1:0]          pass_mask, timeout_mask;
  logic [0:0]             cur_prog;

  int checks = 0;
  int errors = 0;

  // Program table and processor behaviour per program
  logic [63:0] p_start [NP];
  logic [63:0] p_end   [NP];
  logic [63:0] p_exp   [NP];
  logic [63:0] p_step  [NP];   // 0 means the PC never advances
  logic [63:0] p_res   [NP];

  proc_test_sequencer #(
    .NUM_PROGS(NP), .PC_W(PC_W), .DATA_W(DATA_W), .WDOG_W(WDOG_W),
    .WDOG_LIMIT(WDOG_LIMIT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .CLK(CLK), .resetl(resetl), .start(start),
    .prog_start(prog_start), .prog_end(prog_end), .prog_expect(prog_expect),
    .currentpc(currentpc), .MemtoRegOut(MemtoRegOut),
    .dut_resetl(dut_resetl), .dut_startpc(dut_startpc),
    .busy(busy), .done(done), .all_pass(all_pass), .pass_count(pass_count),
    .pass_mask(pass_mask), .timeout_mask(timeout_mask), .cur_prog(cur_prog)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      prog_start[i*PC_W +: PC_W]    = p_start[i];
      prog_end[i*PC_W +: PC_W]      = p_end[i];
      prog_expect[i*DATA_W +: DATA_W] = p_exp[i];
    end
  end

  // Processor model: loads startpc while held in reset, steps PC while running
  int   proc_idx = 0;
  logic rl_q = 1'b0;
  always @(posedge CLK) begin
    rl_q <= dut_resetl;
    if (start && !busy) proc_idx <= 0;
    else if (rl_q && !dut_resetl && proc_idx < NP-1) proc_idx <= proc_idx + 1;
    currentpc <= dut_resetl ? currentpc + p_step[proc_idx] : dut_startpc;
  end
  assign MemtoRegOut = p_res[proc_idx];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_prog(input int i, input logic [63:0] s, input logic [63:0] e,
                          input logic [63:0] x, input logic [63:0] st, input logic [63:0] r);
    p_start[i] = s; p_end[i] = e; p_exp[i] = x; p_step[i] = st; p_res[i] = r;
  endtask

  task automatic run_seq(input string name);
    longint unsigned k;
    int      exp_run [NP];
    int      got_run [NP];
    logic [63:0] got_spc [NP];
    logic [NP-1:0] exp_pm, exp_tm;
    int      exp_cnt, n_exec, total, n, hi_idx, runlen, first_low;
    bit      stopped, prev, seen_hi, ok;

    // Reference outcome from the table and processor behaviour
    exp_pm = '0; exp_tm = '0; exp_cnt = 0; n_exec = 0; total = 0; stopped = 0;
    for (int i = 0; i < NP; i++) begin
      exp_run[i] = 0; got_run[i] = 0; got_spc[i] = '0;
      if (!stopped) begin
        if (p_end[i] <= p_start[i]) k = 0;
        else if (p_step[i] == 0) k = 64'hFFFF_FFFF;
        else k = (p_end[i] - p_start[i] + p_step[i] - 1) / p_step[i];
        ok = 0;
        if (k > WDOG_LIMIT) begin
          exp_run[i] = WDOG_LIMIT + 1;
          exp_tm[i] = 1'b1;
        end else begin
          exp_run[i] = int'(k) + 1;
          if (p_res[i] == p_exp[i]) begin
            ok = 1; exp_pm[i] = 1'b1; exp_cnt++;
          end
        end
        n_exec++;
        total += RST_CYCLES + exp_run[i] + 1;
`ifdef STOP_ON_FAIL_EN
        if (!ok) stopped = 1;
`endif
      end
    end

    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0; hi_idx = 0; runlen = 0; first_low = 0; prev = 0; seen_hi = 0;
    while (!done && n < 3000) begin
      if (dut_resetl) begin
        if (!prev && hi_idx < NP) got_spc[hi_idx] = dut_startpc;
        seen_hi = 1;
        runlen++;
      end else begin
        if (prev) begin
          if (hi_idx < NP) got_run[hi_idx] = runlen;
          hi_idx++;
          runlen = 0;
        end
        if (!seen_hi) first_low++;
      end
      prev = dut_resetl;
      if ($urandom_range(0, 7) == 0) start = 1'b1;  // must be ignored while busy
      @(posedge CLK); #1;
      start = 1'b0;
      n++;
    end

    check({name, " latency"}, 64'(n), 64'(total));
    check({name, " first reset hold"}, 64'(first_low), 64'(RST_CYCLES));
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s run cycles p%0d", name, i), 64'(got_run[i]), 64'(exp_run[i]));
      if (i < n_exec) check($sformatf("%s startpc p%0d", name, i), got_spc[i], p_start[i]);
    end
    check({name, " done"},         64'(done),         64'(1));
    check({name, " busy"},         64'(busy),         64'(0));
    check({name, " dut_resetl"},   64'(dut_resetl),   64'(0));
    check({name, " pass_count"},   64'(pass_count),   64'(exp_cnt));
    check({name, " pass_mask"},    64'(pass_mask),    64'(exp_pm));
    check({name, " timeout_mask"}, 64'(timeout_mask), 64'(exp_tm));
    check({name, " all_pass"},     64'(all_pass),     64'(exp_cnt == NP));
    check({name, " cur_prog"},     64'(cur_prog),     64'(n_exec - 1));
    repeat (2) @(posedge CLK);
    #1;
    check({name, " done held"},    64'(done),         64'(1));
  endtask

  task automatic check_reset_state(input string name);
    check({name, " dut_resetl"},   64'(dut_resetl),   64'(0));
    check({name, " dut_startpc"},  dut_startpc,       64'(0));
    check({name, " busy"},         64'(busy),         64'(0));
    check({name, " done"},         64'(done),         64'(0));
    check({name, " all_pass"},     64'(all_pass),     64'(0));
    check({name, " pass_count"},   64'(pass_count),   64'(0));
    check({name, " pass_mask"},    64'(pass_mask),    64'(0));
    check({name, " timeout_mask"}, 64'(timeout_mask), 64'(0));
    check({name, " cur_prog"},     64'(cur_prog),     64'(0));
  endtask

  task automatic basic_table();
    set_prog(0, 64'h0,  64'h30, 64'hF,                 64'd4, 64'hF);
    set_prog(1, 64'h30, 64'h54, 64'h1234_5678_9abc_def0, 64'd4, 64'h1234_5678_9abc_def0);
  endtask

  initial begin
    int n, rises;
    bit prev;
    logic [63:0] s, d, st, x;

    resetl = 1'b0;
    start  = 1'b0;
    basic_table();
    repeat (3) @(posedge CLK);
    #1;
    check_reset_state("por");
    resetl = 1'b1;
    @(posedge CLK); #1;

    basic_table();
    run_seq("all_pass");

    basic_table();
    p_res[0] = 64'hE;
    run_seq("p0_mismatch");

    basic_table();
    p_step[0] = 64'd0;
    run_seq("p0_timeout");

    basic_table();
    p_end[0] = 64'h3FC;   // end reached when the watchdog equals its limit
    run_seq("end_at_limit");

    basic_table();
    for (int i = 0; i < NP; i++) begin
      p_start[i] = 64'h40; p_end[i] = 64'h40;
    end
    run_seq("start_eq_end");

    // Abort during program 1 RUN
    basic_table();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0; rises = 0; prev = 0;
    while (rises < 2 && n < 1000) begin
      @(posedge CLK); #1;
      if (dut_resetl && !prev) rises++;
      prev = dut_resetl;
      n++;
    end
    check("abort reached p1 run", 64'(rises), 64'(2));
    @(posedge CLK); #1;
    resetl = 1'b0;
    @(posedge CLK); #1;
    check_reset_state("abort");
    resetl = 1'b1;
    @(posedge CLK); #1;
    run_seq("rerun");

    // Randomised tables
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NP; i++) begin
        s  = 64'($urandom_range(0, 1024)) << 2;
        st = 64'($urandom_range(1, 8));
        d  = 64'($urandom_range(0, 300)) * st;
        x  = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) set_prog(i, s, s - 64'($urandom_range(0, 16)), x, st, x);
        else set_prog(i, s, s + d, x, st, ($urandom_range(0, 3) == 0) ? (x ^ 64'h1) : x);
      end
      run_seq($sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_test_sequencer.md
Name: proc_test_sequencer

Overview:
Synthesizable self-test sequencer for the single-cycle processor (`singlecycle`).
- Runs a table of NUM_PROGS programs back-to-back.
- Per program: holds the processor in reset with that program's start PC, releases it, waits until currentpc reaches the program's end PC, and compares MemtoRegOut against the expected value.
- A per-program watchdog bounds each run.
- Reports pass count and per-program pass/timeout masks.
- Sits beside the processor, driving its resetl/startpc and observing currentpc/MemtoRegOut.

Parameters:
- NUM_PROGS, 2: number of programs in the table (≥1).
- PC_W, 64: PC width.
- DATA_W, 64: result width.
- WDOG_W, 16: watchdog counter width.
- WDOG_LIMIT, 255: RUN cycles allowed per program before timeout (< 2^WDOG_W).
- RST_CYCLES, 2: cycles the processor is held in reset per program (≥1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- resetl  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a full sequence.
- prog_start  in  NUM_PROGS*PC_W  start PCs; program i at bits [i*PC_W +: PC_W].
- prog_end  in  NUM_PROGS*PC_W  end PCs; same packing.
- prog_expect  in  NUM_PROGS*DATA_W  expected MemtoRegOut values; same packing.
- currentpc  in  PC_W  processor PC.
- MemtoRegOut  in  DATA_W  processor result.
- dut_resetl  out  1  active-low reset to the processor (registered).
- dut_startpc  out  PC_W  start PC to the processor (registered).
- busy  out  1  sequence in progress.
- done  out  1  sequence complete; held until next start.
- all_pass  out  1  valid when done: pass_count == NUM_PROGS.
- pass_count  out  clog2(NUM_PROGS+1)  programs passed.
- pass_mask  out  NUM_PROGS  bit i set when program i passed.
- timeout_mask  out  NUM_PROGS  bit i set when program i hit the watchdog.
- cur_prog  out  max(1,clog2(NUM_PROGS))  index of current program.

Behaviour:
- Reset (resetl=0 at a rising edge):
  - State goes to IDLE.
  - dut_resetl=0, dut_startpc=0.
  - busy=0, done=0, all_pass=0, pass_count=0, masks=0, cur_prog=0, watchdog=0.
  - Reset mid-sequence aborts the sequence; no partial results are retained.
- States: IDLE, RST, RUN, NEXT, DONE.
- IDLE / DONE:
  - dut_resetl=0.
  - start=1 → clear pass_count, masks, done and all_pass; set cur_prog=0; go to RST; busy=1 from the next cycle.
- RST:
  - dut_resetl=0; dut_startpc=prog_start[cur_prog].
  - Stays exactly RST_CYCLES cycles, then goes to RUN.
  - Watchdog cleared on exit.
- RUN:
  - dut_resetl=1.
  - Each cycle, in priority order:
    1. currentpc ≥ prog_end[cur_prog] (unsigned): if MemtoRegOut == prog_expect[cur_prog], set pass_mask[cur_prog] and increment pass_count. Go to NEXT.
    2. Else if watchdog == WDOG_LIMIT: set timeout_mask[cur_prog], program fails, go to NEXT.
    3. Else increment watchdog.
  - End-reached beats timeout when both occur in the same cycle.
  - If start PC ≥ end PC, the check fires in the first RUN cycle.
- NEXT:
  - dut_resetl=0.
  - If cur_prog == NUM_PROGS-1, go to DONE; else increment cur_prog and go to RST.
- DONE: done=1, busy=0, all_pass registered; results held.
- start while busy is ignored.
- Latency per program: RST_CYCLES + (RUN cycles until end) + 1 (NEXT).

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined: the first failing program (mismatch or timeout) sends NEXT directly to DONE.
  - cur_prog keeps the failing index.
  - Later programs are not run; their mask bits stay 0.
- Undefined: all programs always run.

Test Plan:
1. Model processor; prog0 start 0x0, end 0x30, expect 0xF; prog1 start 0x30, end 0x54, expect 0x123456789abcdef0; model produces matching results → done=1, pass_count=2, pass_mask=2'b11, timeout_mask=0, all_pass=1.
2. Same setup, prog0 model result 0xE → pass_mask=2'b10, pass_count=1, all_pass=0. With STOP_ON_FAIL_EN: pass_mask=0, cur_prog=0, done=1.
3. Model PC never reaches 0x30 in prog0 → timeout_mask[0]=1 after exactly WDOG_LIMIT+1 RUN cycles (256); prog1 then runs and passes.
4. End reached in the same cycle the watchdog equals WDOG_LIMIT, with result matching → counted as pass, timeout bit 0.
5. resetl=0 during prog1 RUN → next cycle: IDLE, dut_resetl=0, all outputs at reset values. Later start → full sequence reruns and passes.
6. start pulses during RST/RUN ignored; prog_start=prog_end=0x40 → check in first RUN cycle; dut_resetl low exactly RST_CYCLES cycles per program.
